// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI3 master-port arbiter.
// The optional round-robin read grant is enabled by defining AXI_ARB_RR_EN.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    localparam logic [3:0] ID_ICACHE  = 4'd0;
    localparam logic [3:0] ID_DCACHE  = 4'd1;
    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_arb_sel.sv
// Two-way read grant selector (I-cache vs D-cache).
// AXI_ARB_RR_EN selects round-robin; otherwise D reads have fixed priority over I reads.
module axi_arb_sel (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic take,
    output logic grant_i,
    output logic grant_d
);

`ifdef AXI_ARB_RR_EN
    // 1 when D won the most recent grant; resets to 1 so I wins the first tie.
    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (take && (i_req || d_req)) begin
            last_grant <= grant_d;
        end
    end

    always_comb begin
        grant_d = d_req && (!i_req || !last_grant);
        grant_i = i_req && !grant_d;
    end
`else
    logic unused_sel;
    assign unused_sel = clk ^ rst_n ^ take;

    always_comb begin
        grant_d = d_req;
        grant_i = i_req && !d_req;
    end
`endif

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI3 master port between I-cache reads, D-cache reads and D-cache writes.
// Build option: AXI_ARB_RR_EN (round-robin read grant, see axi_arb_sel).
module axi_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    // I-cache read
    input  logic                ireq_valid,
    input  logic [ADDR_W-1:0]   ireq_addr,
    input  logic [7:0]          ireq_len,
    input  logic [2:0]          ireq_size,
    output logic                ireq_ready,
    output logic                irsp_valid,
    output logic [DATA_W-1:0]   irsp_data,
    output logic                irsp_last,
    // D-cache read
    input  logic                dreq_valid,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [7:0]          dreq_len,
    input  logic [2:0]          dreq_size,
    output logic                dreq_ready,
    output logic                drsp_valid,
    output logic [DATA_W-1:0]   drsp_data,
    output logic                drsp_last,
    // D-cache write
    input  logic                dw_valid,
    input  logic [ADDR_W-1:0]   dw_addr,
    input  logic [7:0]          dw_len,
    input  logic [2:0]          dw_size,
    output logic                dw_ready,
    input  logic                dw_wvalid,
    input  logic [DATA_W-1:0]   dw_wdata,
    input  logic [DATA_W/8-1:0] dw_wstrb,
    output logic                dw_wready,
    output logic                dw_done,
    // AXI3 AR
    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    // AXI3 R
    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // AXI3 AW
    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    // AXI3 W
    output logic [3:0]          wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    // AXI3 B
    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // FSM state observation
    output logic [1:0]          dbg_rd_state,
    output logic [1:0]          dbg_wr_state
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both 1.
    // valid never depends combinationally on ready on the AXI side.

    rd_state_e rd_state_q, rd_next;
    wr_state_e wr_state_q, wr_next;

    logic              rd_owner_d;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [7:0]        ar_len_q;
    logic [2:0]        ar_size_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [7:0]        aw_len_q;
    logic [2:0]        aw_size_q;
    logic [7:0]        beat_cnt_q;

    logic grant_i, grant_d, d_req_ok;

    // Only one read and one write are ever outstanding, so IDs and responses carry no information.
    logic unused;
    assign unused = ^{rid, rresp, bid, bresp};

    // A D read must not overtake a pending or in-flight D write to the same lines.
    assign d_req_ok = dreq_valid && (wr_state_q == W_IDLE) && !dw_valid;

    axi_arb_sel u_sel (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_req   (ireq_valid),
        .d_req   (d_req_ok),
        .take    (rd_state_q == R_IDLE),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            rd_owner_d <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
        end else begin
            rd_state_q <= rd_next;
            if (rd_state_q == R_IDLE && (grant_i || grant_d)) begin
                rd_owner_d <= grant_d;
                ar_addr_q  <= grant_d ? dreq_addr : ireq_addr;
                ar_len_q   <= grant_d ? dreq_len  : ireq_len;
                ar_size_q  <= grant_d ? dreq_size : ireq_size;
            end
        end
    end

    always_comb begin
        rd_next    = rd_state_q;
        arvalid    = 1'b0;
        rready     = 1'b0;
        ireq_ready = 1'b0;
        dreq_ready = 1'b0;
        case (rd_state_q)
            R_IDLE: if (grant_i || grant_d) rd_next = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    ireq_ready = !rd_owner_d;
                    dreq_ready = rd_owner_d;
                    rd_next    = R_DATA;
                end
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    assign arid    = rd_owner_d ? ID_DCACHE : ID_ICACHE;
    assign araddr  = ar_addr_q;
    assign arlen   = ar_len_q;
    assign arsize  = ar_size_q;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // Caches cannot stall R, so beats are steered straight through to the owner.
    assign irsp_valid = rready && rvalid && !rd_owner_d;
    assign drsp_valid = rready && rvalid && rd_owner_d;
    assign irsp_data  = rdata;
    assign drsp_data  = rdata;
    assign irsp_last  = irsp_valid && rlast;
    assign drsp_last  = drsp_valid && rlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            wr_state_q <= wr_next;
            if (wr_state_q == W_IDLE && dw_valid) begin
                aw_addr_q <= dw_addr;
                aw_len_q  <= dw_len;
                aw_size_q <= dw_size;
            end
            if (wr_state_q != W_DATA) begin
                beat_cnt_q <= '0;
            end else if (dw_wvalid && wready) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        wr_next   = wr_state_q;
        awvalid   = 1'b0;
        dw_ready  = 1'b0;
        wvalid    = 1'b0;
        dw_wready = 1'b0;
        bready    = 1'b0;
        dw_done   = 1'b0;
        case (wr_state_q)
            W_IDLE: if (dw_valid) wr_next = W_AW;
            W_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    dw_ready = 1'b1;
                    wr_next  = W_DATA;
                end
            end
            W_DATA: begin
                wvalid    = dw_wvalid;
                dw_wready = wready;
                if (dw_wvalid && wready && wlast) wr_next = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    dw_done = 1'b1;
                    wr_next = W_IDLE;
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    assign wlast   = (wr_state_q == W_DATA) && (beat_cnt_q == aw_len_q);
    assign awid    = ID_DCACHE;
    assign awaddr  = aw_addr_q;
    assign awlen   = aw_len_q;
    assign awsize  = aw_size_q;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = ID_DCACHE;
    assign wdata   = dw_wdata;
    assign wstrb   = dw_wstrb;

    assign dbg_rd_state = rd_state_q;
    assign dbg_wr_state = wr_state_q;

endmodule

// File: doc/axi_master_arbiter.md
# axi_master_arbiter

Shares the core's single AXI3 master port between three cache-side requesters: I-cache read, D-cache read and D-cache write. It sits between the caches and the top-level AXI pins. It sequences one outstanding read burst and one outstanding write burst. It tags reads with per-requester IDs and routes R beats back to the owner.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- ireq_valid / ireq_addr / ireq_len / ireq_size  in  1/32/8/3  I-cache read request; AXI len/size encoding
- ireq_ready  out  1  pulses on the AR handshake for the I request
- irsp_valid / irsp_data / irsp_last  out  1/32/1  I-cache read beats
- dreq_valid / dreq_addr / dreq_len / dreq_size  in  1/32/8/3  D-cache read request
- dreq_ready  out  1  pulses on the AR handshake for the D request
- drsp_valid / drsp_data / drsp_last  out  1/32/1  D-cache read beats
- dw_valid / dw_addr / dw_len / dw_size  in  1/32/8/3  D-cache write request
- dw_ready  out  1  pulses on the AW handshake
- dw_wvalid / dw_wdata / dw_wstrb  in  1/32/4  write beat from the D-cache
- dw_wready  out  1  write beat accepted
- dw_done  out  1  one-cycle pulse on B received
- arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out; arready  in  AXI3 AR
- rid, rdata, rresp, rlast, rvalid  in; rready  out  AXI3 R
- awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  out; awready  in  AXI3 AW
- wid, wdata, wstrb, wlast, wvalid  out; wready  in  AXI3 W
- bid, bresp, bvalid  in; bready  out  AXI3 B

## Operation
- **Fixed fields:** burst = 2'b01 (INCR); lock, cache and prot = 0. arid = 0 for the I-cache, 1 for the D-cache. awid = wid = 1.
- **Read FSM states:** R_IDLE, R_AR, R_DATA.
  - R_IDLE: grant one requester, latch its addr/len/size and the owner, then go to R_AR.
  - R_AR: arvalid = 1 until arready; the owner's *req_ready pulses on the handshake; then go to R_DATA.
  - R_DATA: rready = 1. R beats are forwarded combinationally to the owner's rsp port. The requester cannot back-pressure. On rvalid & rlast, return to R_IDLE.
- **Read hazard:** a D read is not granted while the write FSM is not in W_IDLE or dw_valid = 1. An I read may still be granted.
- **Write FSM states:** W_IDLE, W_AW, W_DATA, W_RESP.
  - W_IDLE: on dw_valid, latch the request and go to W_AW.
  - W_AW: awvalid = 1; on awready, pulse dw_ready and go to W_DATA.
  - W_DATA: wvalid = dw_wvalid and dw_wready = wready. An 8-bit beat counter drives wlast when count == len. The last-beat handshake moves to W_RESP.
  - W_RESP: bready = 1; on bvalid, pulse dw_done and go to W_IDLE.
- rresp and bresp are ignored. rid and bid are not checked: only one read and one write are ever outstanding.
- **Reset:** arvalid, awvalid, wvalid, rready, bready, all *_ready/*rsp_valid/dw_done = 0. Both FSMs go idle and the counter clears. An in-flight burst is abandoned; the interconnect is reset with the core.

## Timing
- Request seen in R_IDLE at cycle 0 -> arvalid at cycle 1 (registered). AR fields are stable while arvalid = 1.
- After rlast there is one R_IDLE cycle before the next arvalid. Minimum read turnaround is 2 cycles plus slave latency.
- dw_valid at cycle 0 -> awvalid at cycle 1. W beats start no earlier than the cycle after the AW handshake.
- The read and write FSMs run concurrently; AR and AW can be valid in the same cycle.
- Requester inputs must stay stable until their *_ready pulse.

## Configuration
- AXI_ARB_RR_EN defined: 2-way round-robin between I and D reads. A last_grant register selects the requester not granted last. It resets so that I wins the first tie.
- Not defined: fixed priority, D read over I read.

## Structure
- Package axi_arb_pkg holds:
  - the rd_state_e and wr_state_e enums
  - ID_ICACHE = 4'd0 and ID_DCACHE = 4'd1
  - BURST_INCR = 2'b01
- Sub-module axi_arb_sel: 2-input grant selector containing the round-robin/priority logic and last_grant. It is the only place AXI_ARB_RR_EN is tested.

## Test plan
- **Single I read:** ireq len 3 at 0x1FC0_0000 -> arid 0, arlen 3, arburst 01. Four beats appear on irsp, irsp_last on the fourth. The drsp port stays silent.
- **Simultaneous I/D read:** both requests in the same cycle. Without the macro, D is granted first (arid 1). With AXI_ARB_RR_EN, I is first, then D.
- **Write burst:** dw len 7 at 0x8000_0100. wstrb 0xF is passed through and wlast is set on the eighth beat only. A bvalid delayed 5 cycles -> dw_done pulses exactly once.
- **Read hazard:** a D read requested during W_DATA is held off until W_IDLE, while a concurrent I read is granted and completes.
- **Back-pressure:** arready low for 10 cycles -> arvalid and araddr are held. wready toggling every cycle -> no beat is lost and the beat counter stays correct.
- **Mid-burst reset:** aresetn low during R_DATA beat 2 -> all valids drop immediately (asynchronous). After release, a new I read completes normally.
